// File: rtl/nand_dq_dly_calib.sv
// NAND DQ read-capture calibration: sweeps every IDELAY tap with training reads,
// then steps each bit back to the centre of its widest passing window.

module nand_dq_dly_calib_bit #(
   parameter int MIN_WINDOW = 4
) (
   input  logic       clk0,
   input  logic       rst0_n,
   input  logic       clr,
   input  logic       mask_set,
   input  logic       smp,
   input  logic       ok,
   input  logic       eval,
   input  logic [4:0] tap,
   output logic [4:0] centre,
   output logic       fail
);
   logic       pass;
   logic [4:0] cur_start, best_start, new_start;
   logic [5:0] cur_len, best_len, new_len;

   assign new_len   = cur_len + 6'd1;
   assign new_start = (cur_len == 6'd0) ? tap : cur_start;
   assign fail      = best_len < 6'(MIN_WINDOW);
   // start + len/2 never exceeds the last tap, so 5 bits hold the sum
   assign centre    = fail ? 5'd0 : best_start + best_len[5:1];

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         pass       <= 1'b0;
         cur_start  <= '0;
         cur_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else begin
         if (mask_set)  pass <= 1'b1;
         else if (smp)  pass <= pass & ok;
         if (clr) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
         end else if (eval) begin
            if (pass) begin
               cur_len   <= new_len;
               cur_start <= new_start;
               // strict compare keeps the earliest of equal windows
               if (new_len > best_len) begin
                  best_len   <= new_len;
                  best_start <= new_start;
               end
            end else begin
               cur_len <= '0;
            end
         end
      end
   end
endmodule

module nand_dq_dly_calib #(
   parameter int                     DQ_WIDTH        = 8,
   parameter int                     NUM_TAPS        = 32,
   parameter logic [DQ_WIDTH-1:0]    PATTERN_RISE    = 8'hA5,
   parameter logic [DQ_WIDTH-1:0]    PATTERN_FALL    = 8'h5A,
   parameter int                     SAMPLES_PER_TAP = 4,
   parameter int                     SETTLE_CYCLES   = 8,
   parameter int                     MIN_WINDOW      = 4,
   parameter int                     ACK_TIMEOUT     = 1023
) (
   input  logic                    clk0,
   input  logic                    rst0_n,
   input  logic                    cal_start,
   output logic                    cal_done,
   output logic                    cal_err,
   output logic                    train_req,
   input  logic                    train_ack,
   input  logic [DQ_WIDTH-1:0]     rd_data_rise,
   input  logic [DQ_WIDTH-1:0]     rd_data_fall,
   output logic                    dlyrst,
   output logic [DQ_WIDTH-1:0]     dlyce,
   output logic                    dlyinc,
   output logic [5*DQ_WIDTH-1:0]   tap_out,
   output logic [DQ_WIDTH-1:0]     fail_bits
);
   localparam int CW = $clog2(ACK_TIMEOUT + SETTLE_CYCLES + 1);
   localparam int SW = $clog2(SAMPLES_PER_TAP + 1);

   typedef enum logic [3:0] {IDLE, TRST, SETTLE, REQ, WAIT, EVAL, STEP, CRST, CSTEP, DONE} state_t;

   state_t                      state, state_nxt;
   logic [CW-1:0]               cnt;
   logic [SW-1:0]               scnt;
   logic [4:0]                  tap, k, k_nxt, max_c;
   logic                        ph, ph_nxt;
   logic                        start_acc, smp, timeout, dlyrst_d, req_d;
   logic [DQ_WIDTH-1:0]         ok, fail_v, dlyce_d;
   logic [DQ_WIDTH-1:0][4:0]    centre;

   assign start_acc = ((state == IDLE) || (state == DONE)) && cal_start;
   assign smp       = (state == WAIT) && train_ack;
   assign timeout   = (state == WAIT) && !train_ack && (cnt == CW'(ACK_TIMEOUT - 1));
   assign ok        = ~(rd_data_rise ^ PATTERN_RISE) & ~(rd_data_fall ^ PATTERN_FALL);

   for (genvar i = 0; i < DQ_WIDTH; i++) begin : g_bit
      nand_dq_dly_calib_bit #(.MIN_WINDOW(MIN_WINDOW)) u_bit (
         .clk0     (clk0),
         .rst0_n   (rst0_n),
         .clr      (start_acc),
         .mask_set (state == SETTLE),
         .smp      (smp),
         .ok       (ok[i]),
         .eval     (state == EVAL),
         .tap      (tap),
         .centre   (centre[i]),
         .fail     (fail_v[i])
      );
   end

   always_comb begin
      max_c = '0;
      for (int i = 0; i < DQ_WIDTH; i++)
         if (centre[i] > max_c) max_c = centre[i];
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      ph_nxt    = ph;
      case (state)
         IDLE, DONE: if (cal_start) state_nxt = TRST;
         TRST:       state_nxt = SETTLE;
         SETTLE:     if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = REQ;
         REQ:        state_nxt = WAIT;
         WAIT: begin
            if (train_ack) state_nxt = (scnt == SW'(SAMPLES_PER_TAP - 1)) ? EVAL : REQ;
            else if (timeout) state_nxt = DONE;
         end
         EVAL:       state_nxt = (tap == 5'(NUM_TAPS - 1)) ? CRST : STEP;
         STEP:       state_nxt = SETTLE;
         CRST: begin
            k_nxt     = '0;
            ph_nxt    = 1'b0;
            state_nxt = (max_c == 5'd0) ? DONE : CSTEP;
         end
         CSTEP: begin
            if (!ph) begin
               ph_nxt = 1'b1;
            end else begin
               k_nxt  = k + 5'd1;
               ph_nxt = 1'b0;
               if (k + 5'd1 == max_c) state_nxt = DONE;
            end
         end
         default:    state_nxt = IDLE;
      endcase
   end

   // Decoded from the next state so the strobes are registered yet aligned with their state
   always_comb begin
      dlyrst_d = (state_nxt == TRST) || (state_nxt == CRST);
      req_d    = (state_nxt == WAIT);
      dlyce_d  = '0;
      if (state_nxt == STEP) begin
         dlyce_d = '1;
      end else if ((state_nxt == CSTEP) && !ph_nxt) begin
         for (int i = 0; i < DQ_WIDTH; i++) dlyce_d[i] = k_nxt < centre[i];
      end
   end

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         cnt       <= '0;
         scnt      <= '0;
         tap       <= '0;
         k         <= '0;
         ph        <= 1'b0;
         dlyrst    <= 1'b0;
         dlyce     <= '0;
         dlyinc    <= 1'b0;
         train_req <= 1'b0;
         cal_done  <= 1'b0;
         cal_err   <= 1'b0;
         fail_bits <= '0;
         tap_out   <= '0;
      end else begin
         k         <= k_nxt;
         ph        <= ph_nxt;
         dlyrst    <= dlyrst_d;
         dlyce     <= dlyce_d;
         dlyinc    <= |dlyce_d;
         train_req <= req_d;
         cnt       <= (state_nxt == state) ? cnt + CW'(1) : '0;
         if (state == SETTLE) scnt <= '0;
         else if (smp)        scnt <= scnt + SW'(1);
         if (start_acc)           tap <= '0;
         else if (state == STEP)  tap <= tap + 5'd1;
         if (state == CRST) fail_bits <= fail_v;
         if (start_acc) begin
            cal_done  <= 1'b0;
            cal_err   <= 1'b0;
            fail_bits <= '0;
         end else if ((state_nxt == DONE) && (state != DONE)) begin
            cal_done <= 1'b1;
            cal_err  <= timeout | (|fail_v);
            if (!timeout) tap_out <= centre;
         end
      end
   end
endmodule
